// File: rtl/squarer_seq_nbit.sv
// Sequential WIDTH-bit squarer: one symmetric partial-product row accumulated per cycle.
// Optional XOR row signature on port `garbage` when SQR_GARBAGE_EN is defined.
module squarer_seq_nbit #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] Y
`ifdef SQR_GARBAGE_EN
    ,
    output logic [2*WIDTH-1:0] garbage
`endif
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [WIDTH-1:0] op_q;
    logic [IW-1:0]    idx;
    logic [PW-1:0]    op_ext;
    logic [PW-1:0]    row;
    logic             last_row;

    assign op_ext   = PW'(op_q);
    assign last_row = (idx == IW'(WIDTH - 1));

    // Row i: diagonal a_i*2^(2i) plus doubled cross terms with every higher bit.
    always_comb begin
        row = '0;
        if (op_q[idx])
            row = (PW'(1) << (2 * idx)) + ((op_ext >> (idx + 1)) << (2 * idx + 2));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = ACCUM;
            ACCUM:   if (last_row)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= '0;
            idx  <= '0;
            Y    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q <= a;
                        idx  <= '0;
                        Y    <= '0;
                    end
                end
                ACCUM: begin
                    Y <= Y + row;
                    if (!last_row)
                        idx <= idx + IW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef SQR_GARBAGE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            garbage <= '0;
        else if (state == IDLE && in_valid)
            garbage <= '0;
        else if (state == ACCUM)
            garbage <= garbage ^ row;
    end
`endif

endmodule

// File: tb/tb_squarer_seq_nbit.sv
// Scoreboard bench for squarer_seq_nbit at WIDTH=4 and WIDTH=8.
// Checks `garbage` too when SQR_GARBAGE_EN is defined.
module tb_squarer_seq_nbit;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv4, ir4, ov4, or4;
    logic [3:0]  a4;
    logic [7:0]  y4;
    logic        iv8, ir8, ov8, or8;
    logic [7:0]  a8;
    logic [15:0] y8;
`ifdef SQR_GARBAGE_EN
    logic [7:0]  g4;
    logic [15:0] g8;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] q4_y[$], q4_g[$], q8_y[$], q8_g[$];

    always #5 clk = ~clk;

    squarer_seq_nbit #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4),
        .out_valid(ov4), .out_ready(or4), .Y(y4)
`ifdef SQR_GARBAGE_EN
        , .garbage(g4)
`endif
    );

    squarer_seq_nbit #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8),
        .out_valid(ov8), .out_ready(or8), .Y(y8)
`ifdef SQR_GARBAGE_EN
        , .garbage(g8)
`endif
    );

    function automatic logic [63:0] ref_garbage(input int w, input logic [31:0] v);
        logic [63:0] g, r;
        g = '0;
        for (int i = 0; i < w; i++) begin
            if (v[i]) begin
                r = 64'd1 << (2 * i);
                for (int j = i + 1; j < w; j++)
                    if (v[j]) r += 64'd1 << (i + j + 1);
                g ^= r;
            end
        end
        return g;
    endfunction

    // Presents one operand to the WIDTH=4 block (assumed idle) and records expectations.
    task automatic issue4(input logic [3:0] v);
        logic [63:0] t;
        @(negedge clk);
        t   = 64'(v);
        iv4 = 1'b1;
        a4  = v;
        q4_y.push_back(t * t);
        q4_g.push_back(ref_garbage(4, 32'(v)));
        @(posedge clk);
        #1;
        iv4 = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        iv4 = 0; a4 = '0; or4 = 1'b1;
        iv8 = 0; a8 = '0; or8 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({ir4, ov4, y4} !== {1'b1, 1'b0, 8'd0}) begin
            n_bad++;
            $display("FAIL reset_w4: ready/valid/Y=%b/%b/%0d expected 1/0/0", ir4, ov4, y4);
        end
        n_cmp++;
        if ({ir8, ov8, y8} !== {1'b1, 1'b0, 16'd0}) begin
            n_bad++;
            $display("FAIL reset_w8: ready/valid/Y=%b/%b/%0d expected 1/0/0", ir8, ov8, y8);
        end
`ifdef SQR_GARBAGE_EN
        n_cmp++;
        if (g4 !== 8'd0 || g8 !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_garbage: g4=%0h g8=%0h expected 0", g4, g8);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic_w4;
        logic [3:0]  vals[3];
        logic [63:0] ey, eg;
        int          lat;
        logic        busy_bad;
        vals = '{4'd15, 4'd10, 4'd0};
        or4  = 1'b1;
        foreach (vals[k]) begin
            issue4(vals[k]);
            lat      = 0;
            busy_bad = 1'b0;
            do begin
                if (ir4 !== 1'b0) busy_bad = 1'b1;
                @(posedge clk);
                #1;
                lat++;
            end while (ov4 !== 1'b1 && lat < 20);
            ey = q4_y.pop_front();
            eg = q4_g.pop_front();
            n_cmp++;
            if (lat != 4) begin
                n_bad++;
                $display("FAIL latency_w4 a=%0d: %0d edges expected 4", vals[k], lat);
            end
            n_cmp++;
            if (busy_bad) begin
                n_bad++;
                $display("FAIL in_ready_busy_w4 a=%0d: in_ready=1 expected 0 during ACCUM", vals[k]);
            end
            n_cmp++;
            if (64'(y4) !== ey) begin
                n_bad++;
                $display("FAIL square_w4 a=%0d: Y=%0d expected %0d", vals[k], y4, ey);
            end
`ifdef SQR_GARBAGE_EN
            n_cmp++;
            if (64'(g4) !== eg) begin
                n_bad++;
                $display("FAIL garbage_w4 a=%0d: garbage=%0h expected %0h", vals[k], g4, eg);
            end
`endif
            @(posedge clk);
            #1;
            n_cmp++;
            if ({ir4, ov4} !== 2'b10) begin
                n_bad++;
                $display("FAIL return_idle_w4 a=%0d: ready/valid=%b%b expected 10", vals[k], ir4, ov4);
            end
        end
    endtask

    task automatic test_back_to_back_w8;
        int          val, received, cyc, last_acc;
        logic [63:0] t, ey, eg;
        logic        overlap;
        val = 0; received = 0; cyc = 0; last_acc = 0; overlap = 1'b0;
        or8 = 1'b1;
        iv8 = 1'b1;
        while (received < 256 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (ov8 === 1'b1 && ir8 === 1'b1) overlap = 1'b1;
            if (ov8 === 1'b1) begin
                ey = q8_y.pop_front();
                eg = q8_g.pop_front();
                received++;
                n_cmp++;
                if (64'(y8) !== ey) begin
                    n_bad++;
                    $display("FAIL square_w8: Y=%0d expected %0d", y8, ey);
                end
`ifdef SQR_GARBAGE_EN
                n_cmp++;
                if (64'(g8) !== eg) begin
                    n_bad++;
                    $display("FAIL garbage_w8: garbage=%0h expected %0h", g8, eg);
                end
`endif
            end
            if (ir8 === 1'b1) begin
                if (val < 256) begin
                    a8 = 8'(val);
                    t  = 64'(val);
                    q8_y.push_back(t * t);
                    q8_g.push_back(ref_garbage(8, 32'(val)));
                    if (val > 0) begin
                        n_cmp++;
                        if (cyc - last_acc != 10) begin
                            n_bad++;
                            $display("FAIL throughput_w8 a=%0d: interval %0d expected 10", val, cyc - last_acc);
                        end
                    end
                    last_acc = cyc;
                    val++;
                end else begin
                    iv8 = 1'b0;
                end
            end
        end
        iv8 = 1'b0;
        n_cmp++;
        if (received != 256) begin
            n_bad++;
            $display("FAIL sweep_w8_timeout: received %0d expected 256", received);
        end
        n_cmp++;
        if (overlap) begin
            n_bad++;
            $display("FAIL in_ready_outside_idle_w8: in_ready=1 with out_valid=1 expected 0");
        end
    endtask

    task automatic test_backpressure_w4;
        int          lat;
        logic        hold_bad;
        logic [63:0] ey, eg;
        or4 = 1'b0;
        issue4(4'd7);
        lat = 0;
        while (ov4 !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_cmp++;
        if (lat != 4) begin
            n_bad++;
            $display("FAIL bp_latency_w4: %0d edges expected 4", lat);
        end
        hold_bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            iv4 = 1'($urandom);
            a4  = 4'($urandom);
            if ({ov4, ir4, y4} !== {1'b1, 1'b0, 8'd49}) hold_bad = 1'b1;
        end
        ey = q4_y.pop_front();
        eg = q4_g.pop_front();
        n_cmp++;
        if (hold_bad || 64'(y4) !== ey) begin
            n_bad++;
            $display("FAIL bp_hold_w4: valid/ready/Y=%b/%b/%0d expected 1/0/%0d stable", ov4, ir4, y4, ey);
        end
`ifdef SQR_GARBAGE_EN
        n_cmp++;
        if (64'(g4) !== eg) begin
            n_bad++;
            $display("FAIL bp_garbage_w4: garbage=%0h expected %0h", g4, eg);
        end
`endif
        iv4 = 1'b0;
        or4 = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({ir4, ov4} !== 2'b10) begin
            n_bad++;
            $display("FAIL bp_release_w4: ready/valid=%b%b expected 10", ir4, ov4);
        end
    endtask

    task automatic test_reset_mid_w4;
        int          lat;
        logic [63:0] ey, eg;
        or4 = 1'b1;
        issue4(4'd13);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        void'(q4_y.pop_front());
        void'(q4_g.pop_front());
        n_cmp++;
        if ({ir4, ov4, y4} !== {1'b1, 1'b0, 8'd0}) begin
            n_bad++;
            $display("FAIL reset_mid_w4: ready/valid/Y=%b/%b/%0d expected 1/0/0", ir4, ov4, y4);
        end
`ifdef SQR_GARBAGE_EN
        n_cmp++;
        if (g4 !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_mid_garbage_w4: garbage=%0h expected 0", g4);
        end
`endif
        #3;
        rst = 1'b0;
        issue4(4'd3);
        lat = 0;
        while (ov4 !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        ey = q4_y.pop_front();
        eg = q4_g.pop_front();
        n_cmp++;
        if (lat != 4 || 64'(y4) !== ey) begin
            n_bad++;
            $display("FAIL after_reset_w4: Y=%0d after %0d edges expected %0d after 4", y4, lat, ey);
        end
`ifdef SQR_GARBAGE_EN
        n_cmp++;
        if (64'(g4) !== eg) begin
            n_bad++;
            $display("FAIL after_reset_garbage_w4: garbage=%0h expected %0h", g4, eg);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic_w4();
        test_back_to_back_w8();
        test_backpressure_w4();
        test_reset_mid_w4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
